// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin stream arbiter: FSM state
// encoding and the constant function used to size channel indices.
package arbiter_pkg;

  // Arbiter FSM states; the encoding is fixed so debug tools can decode it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SEND   = 2'd2
  } state_t;

  // Number of bits needed to index 'value' items (minimum 1 bit).
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        bits = i + 1;
      end else begin
        bits = bits;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Combinational grant selection. Given the request vector and the channel
// served most recently, returns the channel to grant next and whether any
// channel is requesting. MODE 0 searches round-robin starting just after
// last_grant; MODE 1 always favours the lowest requesting index.
module rr_grant_select #(
  parameter int CHANNELS = 4,
  parameter int CW       = 2,
  parameter int MODE     = 0
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CW-1:0]       last_grant,
  output logic [CW-1:0]       grant,
  output logic                valid
);

  // Pick the winning channel. Loops run from the least favoured candidate
  // to the most favoured one so the final overwrite is the winner.
  always_comb begin
    int idx;
    grant = '0;
    idx   = 0;
    valid = |req;
    if (MODE == 1) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        grant = req[CW'(i)] ? CW'(i) : grant;
      end
    end else begin
      for (int k = CHANNELS; k >= 1; k--) begin
        idx   = (int'(last_grant) + k) % CHANNELS;
        grant = req[CW'(idx)] ? CW'(idx) : grant;
      end
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Multi-channel stream arbiter. One word is in flight at a time: a channel
// is granted in IDLE, its word is taken in ACCEPT, and held on the output
// in SEND until downstream acknowledges it. Every output comes straight
// from a register, so no input reaches an output combinationally.
module rr_stream_arbiter
  import arbiter_pkg::*;
#(
  parameter int   WIDTH    = 16,
  parameter int   CHANNELS = 4,
  parameter int   MODE     = 0,
  localparam int  CW       = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_stb,
  output logic [CHANNELS-1:0]       in_ack,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  output logic                      out_stb,
  input  logic                      out_ack
);

  localparam logic [CHANNELS-1:0] ACK_ONE = {{(CHANNELS-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]       LAST_RESET = CW'(CHANNELS - 1);

  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        grant;
  logic [CW-1:0]        grant_next;
  logic [CW-1:0]        last_grant;
  logic [CW-1:0]        last_grant_next;
  logic [CHANNELS-1:0]  ack_next;
  logic [WIDTH-1:0]     out_data_next;
  logic [CW-1:0]        out_chan_next;
  logic                 out_stb_next;

  logic [CW-1:0]        sel_grant;
  logic                 sel_valid;
  logic [WIDTH-1:0]     words [CHANNELS];

  rr_grant_select #(
    .CHANNELS (CHANNELS),
    .CW       (CW),
    .MODE     (MODE)
  ) u_grant_select (
    .req        (in_stb),
    .last_grant (last_grant),
    .grant      (sel_grant),
    .valid      (sel_valid)
  );

  // Split the packed input bus into one word per channel.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      words[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    ack_next        = in_ack;
    out_data_next   = out_data;
    out_chan_next   = out_chan;
    out_stb_next    = out_stb;
    case (state)
      IDLE: begin
        out_stb_next = 1'b0;
        if (sel_valid) begin
          grant_next = sel_grant;
          ack_next   = ACK_ONE << sel_grant;
          state_next = ACCEPT;
        end else begin
          ack_next = '0;
        end
      end
      ACCEPT: begin
        if (in_stb[grant] && in_ack[grant]) begin
          out_data_next = words[grant];
          out_chan_next = grant;
          ack_next      = '0;
          out_stb_next  = 1'b1;
          state_next    = SEND;
        end else begin
          // Grant stays frozen here no matter how the strobes move.
          ack_next = ACK_ONE << grant;
        end
      end
      SEND: begin
        ack_next = '0;
        if (out_stb && out_ack) begin
          out_stb_next    = 1'b0;
          last_grant_next = grant;
          state_next      = IDLE;
        end else begin
          out_stb_next = 1'b1;
        end
      end
      default: begin
        ack_next     = '0;
        out_stb_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any word still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_RESET;
      in_ack     <= '0;
      out_data   <= '0;
      out_chan   <= '0;
      out_stb    <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      in_ack     <= ack_next;
      out_data   <= out_data_next;
      out_chan   <= out_chan_next;
      out_stb    <= out_stb_next;
    end
  end

endmodule

// File: doc/rr_stream_arbiter.md
RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of every data word.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (legal range 2..16).
REQ-003 SHALL have parameter MODE, default 0, arbitration policy (0 = round-robin, 1 = fixed priority, lowest index wins).
REQ-004 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_data  input  CHANNELS*WIDTH  channel i word at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_stb  input  CHANNELS  per-channel strobe; word on in_data is valid.
REQ-008 SHALL have port in_ack  output  CHANNELS  per-channel acknowledge; at most one bit high in any cycle.
REQ-009 SHALL have port out_data  output  WIDTH  forwarded word.
REQ-010 SHALL have port out_chan  output  CW  index of source channel, CW = clog2(CHANNELS).
REQ-011 SHALL have port out_stb  output  1  out_data/out_chan valid.
REQ-012 SHALL have port out_ack  input  1  downstream acknowledge.

Function
REQ-013 SHALL complete a transfer on any edge where stb and ack of the same link are both high; senders hold stb and data until that edge.
REQ-014 SHALL implement a three-state FSM: IDLE, ACCEPT, SEND.
REQ-015 IDLE: when any in_stb bit is high, SHALL register grant per policy, set in_ack[grant]=1, go to ACCEPT; otherwise stay, all acks 0.
REQ-016 ACCEPT: on in_stb[grant] & in_ack[grant], SHALL latch in_data slice into out_data, grant into out_chan, clear in_ack, set out_stb=1, go to SEND; otherwise hold in_ack high and stay.
REQ-017 SEND: on out_stb & out_ack, SHALL clear out_stb, set last_grant=grant, go to IDLE; otherwise hold out_stb, out_data, out_chan stable.
REQ-018 Round-robin SHALL search channels last_grant+1, last_grant+2, ... modulo CHANNELS and pick the first with in_stb high.
REQ-019 Fixed priority SHALL pick the lowest-index channel with in_stb high; last_grant is still updated but unused.
REQ-020 Grant SHALL be sampled only in IDLE; stb changes during ACCEPT or SEND SHALL NOT alter the grant.
REQ-021 Minimum latency: in_stb rise to in_ack high 1 cycle; in_ack transfer to out_stb high 1 cycle.
REQ-022 Peak throughput SHALL be one word per 3 cycles when out_ack is held high.
REQ-023 With all channels requesting continuously in MODE 0, each channel SHALL be served exactly once in every CHANNELS consecutive transfers.
REQ-024 Wrap-around: last_grant = CHANNELS-1 SHALL make channel 0 first in search order.
REQ-025 out_data, out_chan SHALL change only on the ACCEPT transfer edge.

Reset
REQ-026 rst high SHALL override all other behaviour on that edge, including mid-transfer in ACCEPT or SEND.
REQ-027 After reset: state=IDLE, in_ack=0, out_stb=0, out_data=0, out_chan=0, last_grant=CHANNELS-1.
REQ-028 A word accepted but not yet delivered when rst asserts SHALL be discarded.

Structure
REQ-029 Shared package arbiter_pkg SHALL hold the FSM state encoding (IDLE=0, ACCEPT=1, SEND=2) and the clog2 constant function.
REQ-030 Grant selection SHALL be a combinational sub-module rr_grant_select (inputs request vector, last_grant, MODE; output grant index and valid).
REQ-031 Implementation SHALL contain no memories and no combinational path from any input to any output.

Verification
REQ-032 Single request: CHANNELS=4, in_stb=0001, in_data[0]=16'h1234, out_ack=1 -> in_ack=0001 one cycle later; out_data=16'h1234, out_chan=0, out_stb high the next cycle.
REQ-033 Round-robin fairness: MODE 0, all four in_stb held high, out_ack=1 -> out_chan sequence 0,1,2,3,0,1 with transfers 3 cycles apart.
REQ-034 Fixed priority: MODE 1, in_stb=1110 held -> out_chan always 1 for 5 transfers; channels 2 and 3 never acked.
REQ-035 Backpressure: out_ack=0 for 10 cycles in SEND -> out_stb, out_data, out_chan stable, all in_ack 0; out_ack=1 -> transfer completes, FSM back to IDLE next edge.
REQ-036 Reset mid-operation: rst pulsed in SEND with out_stb=1 -> next cycle out_stb=0, in_ack=0; first grant afterwards is channel 0 when in_stb=1111.
REQ-037 Parameter sweep: WIDTH=8 CHANNELS=2 and WIDTH=32 CHANNELS=5 -> each channel's distinct data pattern arrives with matching out_chan, no loss or duplication over 100 random-handshake words.
